// File: rtl/uart_tx_fifo_if.sv
// Push/status/serial-line bundle between the tester FSM and the UART TX block.
interface uart_tx_fifo_if #(
  parameter int FIFO_AW = 4
);
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             full;
  logic             empty;
  logic [FIFO_AW:0] count;
  logic             ovf;
  logic             tx;
  logic             busy;

  modport master (output wr_en, wr_data, input full, empty, count, ovf, tx, busy);
  modport slave  (input wr_en, wr_data, output full, empty, count, ovf, tx, busy);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter, LSB first, TX driven from a flop.
// Optional even-parity bit (8E1) when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 4
) (
  input  logic          CLK,
  input  logic          RST,
  uart_tx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int PW    = FIFO_AW;
  localparam logic [15:0]   BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } state_t;

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] d);
    even_parity = ^d;
  endfunction
`endif

  logic [7:0]    mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_r;
  logic          empty_r;
  logic          ovf_r;
  state_t        state_r;
  logic [15:0]   baud_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          tx_r;
  logic          busy_r;
`ifdef UART_TX_PARITY_EN
  logic          parity_r;
`endif

  logic          push_s;
  logic          pop_s;
  logic          baud_done_s;
  logic [CW-1:0] count_nxt_s;
  logic [7:0]    head_s;

  assign head_s    = mem_r[rd_ptr_r];
  assign bus.full  = full_r;
  assign bus.empty = empty_r;
  assign bus.count = count_r;
  assign bus.ovf   = ovf_r;
  assign bus.tx    = tx_r;
  assign bus.busy  = busy_r;

  // Push/pop qualification and next occupancy.
  always_comb begin
    push_s      = bus.wr_en & ~full_r;
    baud_done_s = (baud_r == 16'd0);
    pop_s       = 1'b0;
    count_nxt_s = count_r;
    if (!empty_r) begin
      if (state_r == ST_IDLE) begin
        pop_s = 1'b1;
      end else if ((state_r == ST_STOP) && baud_done_s) begin
        pop_s = 1'b1;
      end else begin
        pop_s = 1'b0;
      end
    end else begin
      pop_s = 1'b0;
    end
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage; contents need no reset since empty_r guards every read.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.wr_data;
    end
  end

  // FIFO pointers and registered status flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_FULL);
      empty_r <= (count_nxt_s == CW'(0));
      ovf_r   <= bus.wr_en & full_r;
    end
  end

  // Frame sequencer; tx_r/busy_r follow the state one cycle later.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= ST_IDLE;
      baud_r    <= 16'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_r   <= 1'b1;
          busy_r <= 1'b0;
          if (pop_s) begin
            shift_r <= head_s;
`ifdef UART_TX_PARITY_EN
            parity_r <= even_parity(head_s);
`endif
            baud_r  <= BAUD_MAX;
            state_r <= ST_START;
          end
        end
        ST_START: begin
          tx_r   <= 1'b0;
          busy_r <= 1'b1;
          if (baud_done_s) begin
            baud_r    <= BAUD_MAX;
            bit_idx_r <= 3'd0;
            state_r   <= ST_DATA;
          end else begin
            baud_r <= baud_r - 16'd1;
          end
        end
        ST_DATA: begin
          tx_r   <= shift_r[0];
          busy_r <= 1'b1;
          if (baud_done_s) begin
            baud_r  <= BAUD_MAX;
            shift_r <= {1'b0, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_r <= ST_PARITY;
`else
              state_r <= ST_STOP;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            baud_r <= baud_r - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          tx_r   <= parity_r;
          busy_r <= 1'b1;
          if (baud_done_s) begin
            baud_r  <= BAUD_MAX;
            state_r <= ST_STOP;
          end else begin
            baud_r <= baud_r - 16'd1;
          end
        end
`endif
        ST_STOP: begin
          tx_r   <= 1'b1;
          busy_r <= 1'b1;
          if (baud_done_s) begin
            // Back-to-back: reload straight into START so no idle bit appears.
            if (pop_s) begin
              shift_r <= head_s;
`ifdef UART_TX_PARITY_EN
              parity_r <= even_parity(head_s);
`endif
              baud_r  <= BAUD_MAX;
              state_r <= ST_START;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            baud_r <= baud_r - 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          baud_r  <= 16'd0;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: TX/BUSY logged every falling edge, frames decoded against a byte scoreboard.
module tb_uart_tx_fifo;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * CPB;
  localparam int LOG   = 4096;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   n_fail;
  logic tx_log   [LOG];
  logic busy_log [LOG];
  logic [7:0] exp_q [$];

  uart_tx_fifo_if #(.FIFO_AW(4)) bus ();

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Line log indexed by the number of rising edges seen so far.
  always @(negedge clk) begin
    if (cyc < LOG) begin
      tx_log[cyc]   <= bus.tx;
      busy_log[cyc] <= bus.busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b, input logic sb);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    if (sb) exp_q.push_back(b);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic int busy_span(input int from, input int to);
    int n = 0;
    for (int c = from; c < to; c++) if (busy_log[c] === 1'b1) n++;
    return n;
  endfunction

  function automatic int low_span(input int from, input int to);
    int n = 0;
    for (int c = from; c < to; c++) if (tx_log[c] !== 1'b1) n++;
    return n;
  endfunction

  task automatic expect_frame(input string tag, input int st);
    logic [FB-1:0] obs;
    logic [FB-1:0] exp;
    logic [7:0]    e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 8'hxx;
    for (int i = 0; i < FB; i++) obs[i] = tx_log[st + CPB/2 + CPB*i];
`ifdef UART_TX_PARITY_EN
    exp = {1'b1, ^e, e, 1'b0};
`else
    exp = {1'b1, e, 1'b0};
`endif
    check({tag, "_edge"}, 32'({tx_log[st-1], tx_log[st]}), 32'(2'b10));
    check({tag, "_bits"}, 32'(obs), 32'(exp));
  endtask

  initial begin
    int n;
    int r;
    int bad;
    n_checks = 0; n_pass = 0; n_fail = 0;
    rst = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(bus.tx), 32'(1));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_empty", 32'(bus.empty), 32'(1));
    check("rst_full", 32'(bus.full), 32'(0));
    check("rst_count", 32'(bus.count), 32'(0));
    check("rst_ovf", 32'(bus.ovf), 32'(0));
    rst = 1'b1;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.empty !== 1'b1 || bus.count !== 5'd0 || bus.busy !== 1'b0) bad++;
    end
    check("idle_deviations", 32'(bad), 32'(0));

    // Single byte: latency, bit pattern, BUSY length
    push(8'hA5, 1'b1); n = cyc;
    wait_until(n + FRAME + 20);
    expect_frame("a5", n + 2);
    check("a5_busy_len", 32'(busy_span(n, n + FRAME + 15)), 32'(FRAME));
    check("a5_busy_rise", 32'({busy_log[n+1], busy_log[n+2]}), 32'(2'b01));

    // Three contiguous frames
    push(8'h00, 1'b1); n = cyc;
    push(8'hFF, 1'b1);
    push(8'h3C, 1'b1);
    wait_until(n + 2 + 3*FRAME + 4);
    for (int k = 0; k < 3; k++) expect_frame("b2b", n + 2 + FRAME*k);
    check("b2b_busy", 32'(busy_span(n + 2, n + 2 + 3*FRAME + 2)), 32'(3*FRAME));
    check("b2b_empty", 32'(bus.empty), 32'(1));

    // Fill to FULL while a frame holds the shifter, then overflow
    push(8'h11, 1'b1); n = cyc;
    for (int k = 0; k < 16; k++) push(8'h40 + 8'(k), 1'b1);
    check("fill_full", 32'(bus.full), 32'(1));
    check("fill_count", 32'(bus.count), 32'(16));
    check("fill_ovf_lo", 32'(bus.ovf), 32'(0));
    push(8'hEE, 1'b0);
    check("ovf_pulse", 32'(bus.ovf), 32'(1));
    check("ovf_count", 32'(bus.count), 32'(16));
    @(negedge clk);
    check("ovf_clear", 32'(bus.ovf), 32'(0));
    wait_until(n + 2 + 17*FRAME + 4);
    for (int k = 0; k < 17; k++) expect_frame("fill", n + 2 + FRAME*k);
    check("fill_drained", 32'(bus.empty), 32'(1));

    // Write at FULL coinciding with a pop
    push(8'h20, 1'b1); n = cyc;
    for (int k = 0; k < 16; k++) push(8'h60 + 8'(k), 1'b1);
    wait_until(n + FRAME);
    check("popfull_full", 32'(bus.full), 32'(1));
    push(8'hEE, 1'b0);
    check("popfull_ovf", 32'(bus.ovf), 32'(1));
    check("popfull_count", 32'(bus.count), 32'(15));
    wait_until(n + 2 + 17*FRAME + 4);
    for (int k = 0; k < 17; k++) expect_frame("popfull", n + 2 + FRAME*k);

    // Push with a pop at COUNT=8
    push(8'h30, 1'b1); n = cyc;
    for (int k = 0; k < 8; k++) push(8'h80 + 8'(k), 1'b1);
    wait_until(n + FRAME);
    check("mid_count_pre", 32'(bus.count), 32'(8));
    push(8'h99, 1'b1);
    check("mid_count_post", 32'(bus.count), 32'(8));
    check("mid_ovf", 32'(bus.ovf), 32'(0));
    wait_until(n + 2 + 10*FRAME + 4);
    for (int k = 0; k < 10; k++) expect_frame("mid", n + 2 + FRAME*k);

    // Async reset during DATA bit 3 of 0x55, one more byte queued
    push(8'h55, 1'b0); n = cyc;
    push(8'h66, 1'b0);
    wait_until(n + 2 + CPB*4 + 1);
    check("pre_rst_tx", 32'(bus.tx), 32'(0));
    rst = 1'b0;
    #1;
    check("arst_tx", 32'(bus.tx), 32'(1));
    check("arst_busy", 32'(bus.busy), 32'(0));
    check("arst_empty", 32'(bus.empty), 32'(1));
    check("arst_count", 32'(bus.count), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    push(8'hC3, 1'b1); r = cyc;
    wait_until(r + 2 + FRAME + 4);
    check("arst_quiet", 32'(low_span(n + 2 + CPB*4 + 2, r + 2)), 32'(0));
    expect_frame("after_rst", r + 2);

`ifdef UART_TX_PARITY_EN
    push(8'h07, 1'b1); n = cyc;
    wait_until(n + FRAME + 20);
    check("par_bit", 32'(tx_log[n + 2 + CPB/2 + CPB*9]), 32'(1));
    expect_frame("par07", n + 2);
    check("par_busy_len", 32'(busy_span(n, n + FRAME + 15)), 32'(44));
`endif

    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit half of the tester's host UART link. Complements the RX path that receives test vectors.
- Buffers response bytes (captured DUT outputs, counter values, status) in a small FIFO and serialises them onto TX as 8N1 frames, LSB first.
- Sits between the central FSM and the TX pin; the FSM pushes bytes and never waits on bit timing.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2 to 65535
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW (16)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- WR_EN  in  1  push WR_DATA into FIFO this cycle
- WR_DATA  in  8  byte to transmit
- FULL  out  1  FIFO holds 2**FIFO_AW bytes
- EMPTY  out  1  FIFO holds 0 bytes
- COUNT  out  FIFO_AW+1  bytes currently in FIFO (excludes byte in shifter)
- OVF  out  1  one-cycle pulse: write attempted while FULL, byte dropped
- TX  out  1  serial line, idle high
- BUSY  out  1  high while a frame (start..stop) is on the line

Behaviour:
- Reset (RST low, async): TX=1, BUSY=0, FIFO pointers=0, COUNT=0, EMPTY=1, FULL=0, OVF=0, state=IDLE, bit/baud counters=0. Mid-frame reset aborts the frame immediately; TX returns high with no glitch low.
- FIFO:
  - Push when WR_EN & !FULL.
  - WR_EN & FULL drops the byte and pulses OVF for one cycle, even if a pop occurs that same cycle.
  - Push and pop in the same cycle leave COUNT unchanged.
  - FULL, EMPTY and COUNT are registered and reflect the previous edge. A byte pushed into an empty FIFO is poppable on the following cycle.
  - Pointers wrap modulo depth.
- State machine, all transitions on the rising edge of CLK:
  - IDLE: TX=1, BUSY=0. If !EMPTY, pop the head into the shift register and go to START.
  - START: TX=0, BUSY=1, for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: TX=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles. On its last cycle:
    - if !EMPTY, pop and go directly to START, so frames are back-to-back with no idle gap and BUSY stays 1;
    - otherwise go to IDLE.
- Latency: a push into an idle, empty FIFO at edge N drives TX low at edge N+2.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- The baud counter is a down-counter reloaded at each bit boundary; no fractional baud.
- TX is driven straight from a flop, so the pin never sees a combinational glitch.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP. TX = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles. Frame = 11*CLKS_PER_BIT cycles. All other timing is unchanged.
- When undefined: the PARITY state and its logic are absent; frames are 8N1, 10 bits.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4: TX=1, EMPTY=1, COUNT=0, BUSY=0 for 100 cycles with no writes.
- Single byte 0xA5 pushed at edge N: TX falls at N+2. Bit sampling at bit centres gives 0,1,0,1,0,0,1,0,1 then stop 1. BUSY=1 for exactly 40 cycles, then 0.
- Push 0x00, 0xFF, 0x3C consecutively: three contiguous frames with no idle cycle between them (stop bit of frame k is followed immediately by the start bit of k+1). Decoded bytes are in order. EMPTY=1 after the third pop.
- With TX stalled in a frame, push 17 bytes: FULL asserts after byte 16, the 17th push pulses OVF for one cycle, and COUNT=16. All 16 bytes are then transmitted in order.
- Push with a simultaneous pop at FULL: OVF=1 and the byte is dropped; COUNT falls to 15. Push at COUNT=8 with a simultaneous pop: COUNT stays 8.
- RST low during DATA bit 3 of 0x55: TX=1 within the same cycle (async), FIFO empty, and a new byte transmits cleanly after release. With UART_TX_PARITY_EN: 0x07 gives parity bit 1 and a 44-cycle frame.
